uart_fifo_core: RTL and testbench



---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_fifo.sv | 59 +++++
 rtl/uart_fifo_core.sv | 268 ++++++++++++++++++++++++++
 tb/tb_uart_fifo_core.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and bit-timing constants shared by the UART FSMs.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

  localparam int START_SAMPLE = 7;
  localparam int BIT_TICKS    = 16;
  localparam int TICK_CW      = 6;  // tick counter width, covers stop lengths up to 64 ticks

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: first-word-fall-through FIFO with registered full/empty.
// Writes while full are dropped even if a read happens in the same cycle.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_AW    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr, rd_ptr;
  logic [FIFO_AW:0]      count, count_n;
  logic                  wr_en, rd_en;

  assign wr_en = wr && !full;
  assign rd_en = rd && !empty;

  always_comb begin
    count_n = count;
    if (wr_en && !rd_en)      count_n = count + 1'b1;
    else if (rd_en && !wr_en) count_n = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
      full  <= (count_n == FULL_CNT);
      empty <= (count_n == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Head reads as zero while empty so stale entries never leak out after reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: buffered UART with runtime baud divisor, TX/RX FIFOs and sticky errors.
// Define UART_PARITY_EN to add a parity bit and the parity_odd / parity_err ports.
//
// state  | meaning
// IDLE   | line idle; RX waits for a falling edge, TX waits for FIFO data
// START  | start bit (RX resamples at mid-bit to reject glitches)
// DATA   | DATA_WIDTH bits, LSB first, 16 ticks each
// PARITY | parity bit, 16 ticks (UART_PARITY_EN builds only)
// STOP   | stop bit, SB_TICK ticks
module uart_fifo_core
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SB_TICK    = 16,
  parameter int FIFO_AW    = 4,
  parameter int DVSR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DVSR_WIDTH-1:0] dvsr,
  input  logic                  rx,
  output logic                  tx,
  input  logic                  tx_wr,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_full,
  output logic                  tx_empty,
  output logic                  tx_busy,
  input  logic                  rx_rd,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_full,
  output logic                  rx_empty,
  output logic                  rx_overrun,
  output logic                  frame_err,
`ifdef UART_PARITY_EN
  input  logic                  parity_odd,
  output logic                  parity_err,
`endif
  input  logic                  clr_err
);

  localparam int NW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [TICK_CW-1:0] MID_CNT   = TICK_CW'(START_SAMPLE);
  localparam logic [TICK_CW-1:0] BIT_LAST  = TICK_CW'(BIT_TICKS - 1);
  localparam logic [TICK_CW-1:0] STOP_LAST = TICK_CW'(SB_TICK - 1);
  localparam logic [NW-1:0]      BITS_LAST = NW'(DATA_WIDTH - 1);
`ifdef UART_PARITY_EN
  localparam uart_state_t AFTER_DATA = PARITY;
`else
  localparam uart_state_t AFTER_DATA = STOP;
`endif

  // >= compare lets a shrinking divisor take effect at once instead of wrapping.
  logic [DVSR_WIDTH-1:0] tick_cnt;
  logic                  tick;
  assign tick = (tick_cnt >= dvsr);

  always_ff @(posedge clk) begin
    if (reset) tick_cnt <= '0;
    else       tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  logic                  tx_pop, rx_push;
  logic [DATA_WIDTH-1:0] tx_head;

  uart_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_AW(FIFO_AW)) u_tx_fifo (
    .clk(clk), .reset(reset), .wr(tx_wr), .wr_data(tx_data),
    .rd(tx_pop), .rd_data(tx_head), .full(tx_full), .empty(tx_empty)
  );

  uart_state_t           rx_state, rx_state_n;
  logic [TICK_CW-1:0]    rx_scnt, rx_scnt_n;
  logic [NW-1:0]         rx_ncnt, rx_ncnt_n;
  logic [DATA_WIDTH-1:0] rx_shift, rx_shift_n;
  logic [1:0]            rx_sync;
  logic                  rx_s, frame_set;
`ifdef UART_PARITY_EN
  logic                  par_set;
`endif

  uart_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_AW(FIFO_AW)) u_rx_fifo (
    .clk(clk), .reset(reset), .wr(rx_push), .wr_data(rx_shift),
    .rd(rx_rd), .rd_data(rx_data), .full(rx_full), .empty(rx_empty)
  );

  assign rx_s = rx_sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync  <= 2'b11;
      rx_state <= IDLE;
      rx_scnt  <= '0;
      rx_ncnt  <= '0;
      rx_shift <= '0;
    end else begin
      rx_sync  <= {rx_sync[0], rx};
      rx_state <= rx_state_n;
      rx_scnt  <= rx_scnt_n;
      rx_ncnt  <= rx_ncnt_n;
      rx_shift <= rx_shift_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_scnt_n  = rx_scnt;
    rx_ncnt_n  = rx_ncnt;
    rx_shift_n = rx_shift;
    rx_push    = 1'b0;
    frame_set  = 1'b0;
`ifdef UART_PARITY_EN
    par_set    = 1'b0;
`endif
    case (rx_state)
      IDLE: if (!rx_s) begin
        rx_state_n = START;
        rx_scnt_n  = '0;
      end
      START: if (tick) begin
        if (rx_scnt == MID_CNT) begin
          rx_state_n = rx_s ? IDLE : DATA;
          rx_scnt_n  = '0;
          rx_ncnt_n  = '0;
        end else rx_scnt_n = rx_scnt + 1'b1;
      end
      DATA: if (tick) begin
        if (rx_scnt == BIT_LAST) begin
          rx_scnt_n  = '0;
          rx_shift_n = {rx_s, rx_shift[DATA_WIDTH-1:1]};
          if (rx_ncnt == BITS_LAST) rx_state_n = AFTER_DATA;
          else                      rx_ncnt_n  = rx_ncnt + 1'b1;
        end else rx_scnt_n = rx_scnt + 1'b1;
      end
`ifdef UART_PARITY_EN
      PARITY: if (tick) begin
        if (rx_scnt == BIT_LAST) begin
          rx_scnt_n  = '0;
          rx_state_n = STOP;
          par_set    = rx_s ^ (^rx_shift) ^ parity_odd;
        end else rx_scnt_n = rx_scnt + 1'b1;
      end
`endif
      STOP: if (tick) begin
        if (rx_scnt == STOP_LAST) begin
          rx_state_n = IDLE;
          rx_push    = rx_s;
          frame_set  = !rx_s;
        end else rx_scnt_n = rx_scnt + 1'b1;
      end
      default: rx_state_n = IDLE;
    endcase
  end

  uart_state_t           tx_state, tx_state_n;
  logic [TICK_CW-1:0]    tx_scnt, tx_scnt_n;
  logic [NW-1:0]         tx_ncnt, tx_ncnt_n;
  logic [DATA_WIDTH-1:0] tx_shift, tx_shift_n;
  logic                  tx_line;
`ifdef UART_PARITY_EN
  logic                  tx_par, tx_par_n;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= IDLE;
      tx_scnt  <= '0;
      tx_ncnt  <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_state <= tx_state_n;
      tx_scnt  <= tx_scnt_n;
      tx_ncnt  <= tx_ncnt_n;
      tx_shift <= tx_shift_n;
      tx       <= tx_line;
      tx_busy  <= (tx_state != IDLE);
`ifdef UART_PARITY_EN
      tx_par   <= tx_par_n;
`endif
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_scnt_n  = tx_scnt;
    tx_ncnt_n  = tx_ncnt;
    tx_shift_n = tx_shift;
    tx_line    = 1'b1;
    tx_pop     = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_n   = tx_par;
`endif
    case (tx_state)
      IDLE: tx_pop = !tx_empty;
      START: begin
        tx_line = 1'b0;
        if (tick) begin
          if (tx_scnt == BIT_LAST) begin
            tx_scnt_n  = '0;
            tx_ncnt_n  = '0;
            tx_state_n = DATA;
          end else tx_scnt_n = tx_scnt + 1'b1;
        end
      end
      DATA: begin
        tx_line = tx_shift[0];
        if (tick) begin
          if (tx_scnt == BIT_LAST) begin
            tx_scnt_n  = '0;
            tx_shift_n = tx_shift >> 1;
            if (tx_ncnt == BITS_LAST) tx_state_n = AFTER_DATA;
            else                      tx_ncnt_n  = tx_ncnt + 1'b1;
          end else tx_scnt_n = tx_scnt + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        tx_line = tx_par;
        if (tick) begin
          if (tx_scnt == BIT_LAST) begin
            tx_scnt_n  = '0;
            tx_state_n = STOP;
          end else tx_scnt_n = tx_scnt + 1'b1;
        end
      end
`endif
      STOP: if (tick) begin
        if (tx_scnt == STOP_LAST) begin
          tx_state_n = IDLE;
          tx_pop     = !tx_empty;
        end else tx_scnt_n = tx_scnt + 1'b1;
      end
      default: tx_state_n = IDLE;
    endcase
    // Loading from STOP chains frames back to back with no idle bit.
    if (tx_pop) begin
      tx_state_n = START;
      tx_scnt_n  = '0;
      tx_shift_n = tx_head;
`ifdef UART_PARITY_EN
      tx_par_n   = (^tx_head) ^ parity_odd;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (rx_push && rx_full) rx_overrun <= 1'b1;
      else if (clr_err)       rx_overrun <= 1'b0;
      if (frame_set)          frame_err  <= 1'b1;
      else if (clr_err)       frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
      if (par_set)            parity_err <= 1'b1;
      else if (clr_err)       parity_err <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_uart_fifo_core.sv
// tb_uart_fifo_core: scoreboard bench for uart_fifo_core (TX waveform, loopback,
// overrun, glitch/frame errors, mid-frame reset; parity when UART_PARITY_EN is set).
module tb_uart_fifo_core;

`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NBITS       = 1 + 8 + PB;
  localparam int FRAME_TICKS = 16 * NBITS + 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] dvsr = '0;
  logic        rx, tx;
  logic        tx_wr = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        tx_full, tx_empty, tx_busy;
  logic        rx_rd = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_full, rx_empty, rx_overrun, frame_err;
  logic        clr_err = 1'b0;
`ifdef UART_PARITY_EN
  logic        parity_odd = 1'b0;
  logic        parity_err;
`endif
  logic        loop = 1'b0;
  logic        rx_drv = 1'b1;

  assign rx = loop ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_fifo_core dut (
    .clk(clk), .reset(reset), .dvsr(dvsr), .rx(rx), .tx(tx),
    .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full), .tx_empty(tx_empty),
    .tx_busy(tx_busy), .rx_rd(rx_rd), .rx_data(rx_data), .rx_full(rx_full),
    .rx_empty(rx_empty), .rx_overrun(rx_overrun), .frame_err(frame_err),
`ifdef UART_PARITY_EN
    .parity_odd(parity_odd), .parity_err(parity_err),
`endif
    .clr_err(clr_err)
  );

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
`ifdef UART_PARITY_EN
    if (k == 9) return (^d) ^ parity_odd;
`endif
    return 1'b1;
  endfunction

  task automatic push_tx(input logic [7:0] d, input bit expect_rx);
    int n = 0;
    while (tx_full && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq("tx_room", tx_full, 0);
    tx_wr = 1'b1;
    tx_data = d;
    if (expect_rx) exp_q.push_back(d);
    @(negedge clk);
    tx_wr = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    int n = 0;
    logic [7:0] e;
    while (rx_empty && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_avail"}, rx_empty, 0);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 'x;
    check_eq(tag, rx_data, e);
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
  endtask

  task automatic send_rx_frame(input logic [7:0] d, input logic par, input bit stop_ok);
    int tk = int'(dvsr) + 1;
    rx_drv = 1'b0;
    repeat (16 * tk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (16 * tk) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    rx_drv = par;
    repeat (16 * tk) @(negedge clk);
`else
    rx_drv = par | 1'b1;
`endif
    if (stop_ok) begin
      rx_drv = 1'b1;
      repeat (16 * tk) @(negedge clk);
    end else begin
      rx_drv = 1'b0;
      repeat (12 * tk) @(negedge clk);
      rx_drv = 1'b1;
      repeat (4 * tk) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (16 * tk) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int errs;
    logic e;

    repeat (4) @(negedge clk);
    check_eq("rst_tx", tx, 1);
    check_eq("rst_tx_busy", tx_busy, 0);
    check_eq("rst_tx_empty", tx_empty, 1);
    check_eq("rst_tx_full", tx_full, 0);
    check_eq("rst_rx_empty", rx_empty, 1);
    check_eq("rst_rx_full", rx_full, 0);
    check_eq("rst_rx_data", rx_data, 0);
    check_eq("rst_overrun", rx_overrun, 0);
    check_eq("rst_frame_err", frame_err, 0);
`ifdef UART_PARITY_EN
    check_eq("rst_parity_err", parity_err, 0);
`endif
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // dvsr=0: exact bit-level waveform of 0x55
    tx_wr = 1'b1;
    tx_data = 8'h55;
    @(negedge clk);
    tx_wr = 1'b0;
    check_eq("tx_wr_edge_idle", tx, 1);
    @(negedge clk);
    check_eq("tx_first_edge_idle", tx, 1);
    errs = 0;
    for (int i = 0; i <= 16 * NBITS + 16; i++) begin
      @(negedge clk);
      e = (i < 16 * NBITS + 16) ? frame_bit(8'h55, i / 16) : 1'b1;
      if (tx !== e) errs++;
      if (tx_busy !== (i < 16 * NBITS + 16)) errs++;
    end
    check_eq("tx_wave_55", errs, 0);
    check_eq("tx_busy_drop", tx_busy, 0);

    // loopback, dvsr=3, back-to-back frames
    dvsr = 11'd3;
    loop = 1'b1;
    repeat (10) @(negedge clk);
    push_tx(8'hA5, 1'b1);
    push_tx(8'h3C, 1'b1);
    n = 0;
    while (!tx_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("b2b_busy_rise", tx_busy, 1);
    n = 0;
    while (tx_busy && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check_eq("b2b_no_gap", (n >= 2 * FRAME_TICKS * 4 - 3) && (n <= 2 * FRAME_TICKS * 4), 1);
    pop_check("lb_a5");
    pop_check("lb_3c");
    check_eq("lb_empty_after", rx_empty, 1);

    // 17 frames + a write while TX FIFO full, no RX reads
    dvsr = 11'd0;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 17; i++) push_tx(8'(8'h10 + i * 7), i < 16);
    check_eq("tx_full_17", tx_full, 1);
    tx_wr = 1'b1;
    tx_data = 8'hEE;
    @(negedge clk);
    tx_wr = 1'b0;
    n = 0;
    while ((!tx_empty || tx_busy) && n < 8000) begin
      @(negedge clk);
      n++;
    end
    check_eq("tx_drain", tx_busy, 0);
    repeat (300) @(negedge clk);
    check_eq("ovr_rx_full", rx_full, 1);
    check_eq("ovr_flag", rx_overrun, 1);
    check_eq("ovr_no_frame_err", frame_err, 0);
    for (int i = 0; i < 16; i++) pop_check("ovr_data");
    check_eq("ovr_drained", rx_empty, 1);
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
    check_eq("rd_empty_ignored", rx_empty, 1);
    check_eq("rd_empty_data", rx_data, 0);
    pulse_clr();
    check_eq("ovr_cleared", rx_overrun, 0);

    // glitch rejection and frame error, driven directly on rx
    loop = 1'b0;
    dvsr = 11'd3;
    repeat (20) @(negedge clk);
    rx_drv = 1'b0;
    repeat (16) @(negedge clk);
    rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    check_eq("glitch_no_frame", rx_empty, 1);
    check_eq("glitch_no_err", frame_err, 0);
    send_rx_frame(8'h5A, 1'b0, 1'b0);
    repeat (120) @(negedge clk);
    check_eq("bad_stop_err", frame_err, 1);
    check_eq("bad_stop_discard", rx_empty, 1);
    pulse_clr();
    check_eq("frame_err_cleared", frame_err, 0);
    exp_q.push_back(8'hC3);
    send_rx_frame(8'hC3, 1'b0, 1'b1);
    pop_check("rx_manual_c3");

`ifdef UART_PARITY_EN
    parity_odd = 1'b1;
    exp_q.push_back(8'h01);
    send_rx_frame(8'h01, 1'b1, 1'b1);
    pop_check("par_bad_stored");
    check_eq("par_bad_flag", parity_err, 1);
    pulse_clr();
    check_eq("par_cleared", parity_err, 0);
    exp_q.push_back(8'h01);
    send_rx_frame(8'h01, 1'b0, 1'b1);
    pop_check("par_good_stored");
    check_eq("par_good_flag", parity_err, 0);
    parity_odd = 1'b0;
`endif

    // reset in the middle of a data bit with bytes queued
    for (int i = 0; i < 3; i++) push_tx(8'(8'h81 + i), 1'b0);
    repeat (16 * 4 + 40) @(negedge clk);
    check_eq("mid_frame_busy", tx_busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_tx", tx, 1);
    check_eq("rst_mid_tx_empty", tx_empty, 1);
    check_eq("rst_mid_tx_busy", tx_busy, 0);
    check_eq("rst_mid_rx_empty", rx_empty, 1);
    reset = 1'b0;
    errs = 0;
    repeat (1500) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) errs++;
    end
    check_eq("rst_no_more_frames", errs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
